dft_trace_streamer: RTL

Buffered debug-trace streamer between the MIPS core's DFT outputs and the byte UART. Each register-write event (PC, address, data) is captured into a FIFO of FIFO_DEPTH records. Each record is serialised as a framed byte stream, and bytes are handed to the UART under a real wr/busy handshake. Lost events are counted, never silently dropped.

---
 rtl/dft_trace_streamer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dft_trace_streamer.sv
`default_nettype none
// ============================================================================
// Module      : dft_trace_streamer
// Description : Buffers register-write trace events from the core's DFT
//               outputs in a record FIFO and serialises each record as a
//               framed byte stream (sync byte, PC, Address, Data; MSB first)
//               towards a byte UART using a wr/busy handshake. Events that
//               arrive while the FIFO is full are counted, not lost silently.
// Revision    : 1.0 - initial release
// ============================================================================
module dft_trace_streamer #(
  parameter int         BIT_WIDTH  = 32,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trace_en,
  input  logic                          RegWrite,
  input  logic [BIT_WIDTH-1:0]          PC,
  input  logic [BIT_WIDTH-1:0]          Address,
  input  logic [BIT_WIDTH-1:0]          Data,
  input  logic                          uart_busy,
  output logic                          uart_wr_i,
  output logic [7:0]                    uart_dat_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count,
  output logic                          idle
);

  localparam int c_BYTES   = BIT_WIDTH / 8;
  localparam int c_NBYTES  = 1 + 3 * c_BYTES;
  localparam int c_REC_W   = 3 * BIT_WIDTH;
  localparam int c_FRAME_W = 8 * c_NBYTES;
  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W   = c_PTR_W + 1;
  localparam int c_CNT_W   = $clog2(c_NBYTES);

  localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_NBYTES - 1);
  localparam logic [7:0]         c_DROP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GUARD = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // Record storage and bookkeeping
  logic [c_REC_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_LVL_W-1:0]   r_fifo_level;
  logic [7:0]           r_drop_count;

  // Serializer state
  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_FRAME_W-1:0] r_shift;
  logic [c_CNT_W-1:0]   r_byte_cnt;
  logic                 r_uart_wr;
  logic [7:0]           r_uart_dat;

  // Handshake/control strobes
  logic                 w_push_req;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_load;
  logic                 w_issue;
  logic                 w_advance;
  logic                 w_last_byte;

  assign w_push_req  = RegWrite && trace_en;
  assign w_full      = (r_fifo_level == c_FULL_LVL);
  assign w_empty     = (r_fifo_level == '0);
  assign w_last_byte = (r_byte_cnt == c_LAST_CNT);

  // A pop in the same cycle frees a slot, so a capture into a full FIFO is
  // still accepted when the serializer is taking a record out.
  assign w_push = w_push_req && (!w_full || w_load);
  assign w_drop = w_push_req && w_full && !w_load;

  // Serializer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    w_advance   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!uart_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = S_GUARD;
        end
      end
      S_GUARD: begin
        // The UART raises busy one cycle after a write; skip that cycle
        // before trusting busy again.
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!uart_busy) begin
          if (w_last_byte) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Record storage write port; contents need no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {PC, Address, Data};
    end
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_level <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      unique case ({w_push, w_load})
        2'b10:   r_fifo_level <= r_fifo_level + c_LVL_W'(1);
        2'b01:   r_fifo_level <= r_fifo_level - c_LVL_W'(1);
        default: r_fifo_level <= r_fifo_level;
      endcase
      if (w_drop && (r_drop_count != c_DROP_MAX)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  // Frame shift register, byte counter and registered UART write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_uart_wr  <= 1'b0;
      r_uart_dat <= 8'h00;
    end else begin
      r_uart_wr <= w_issue;
      if (w_issue) begin
        r_uart_dat <= r_shift[c_FRAME_W-1 -: 8];
      end
      if (w_load) begin
        r_shift    <= {SYNC_BYTE, r_mem[r_rd_ptr]};
        r_byte_cnt <= '0;
      end else if (w_advance) begin
        r_shift    <= {r_shift[c_FRAME_W-9:0], 8'h00};
        r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
      end
    end
  end

  assign uart_wr_i  = r_uart_wr;
  assign uart_dat_i = r_uart_dat;
  assign fifo_level = r_fifo_level;
  assign drop_count = r_drop_count;
  assign idle       = (r_state == S_IDLE) && w_empty;

endmodule
`default_nettype wire
